// File: rtl/utim64_irq_ctrl_pkg.sv
// ============================================================================
// Module  : utim64_irq_ctrl_pkg
// Purpose : Shared defaults and FSM state encoding for the utim64 IRQ stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package utim64_irq_ctrl_pkg;

  localparam int CH_NUM_DEF = 4;
  localparam int NUM_W_DEF  = 2;
  localparam int MISS_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/utim64_irq_ctrl_if.sv
// ============================================================================
// Module  : utim64_irq_ctrl_if
// Purpose : Register-access and request/ack handshake bundle of the IRQ stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface utim64_irq_ctrl_if
  import utim64_irq_ctrl_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int NUM_W  = NUM_W_DEF
);

  logic              iMASK_WRITE;
  logic [CH_NUM-1:0] iMASK_DATA;
  logic              iCLEAR_WRITE;
  logic [CH_NUM-1:0] iCLEAR_DATA;
  logic [CH_NUM-1:0] oPENDING;
  logic [CH_NUM-1:0] oMASK;
  logic              oREQ_VALID;
  logic [NUM_W-1:0]  oREQ_NUM;
  logic              iREQ_ACK;

  // Master is the IRQ stage (it originates requests); slave is the host/controller.
  modport master (
    input  iMASK_WRITE, iMASK_DATA, iCLEAR_WRITE, iCLEAR_DATA, iREQ_ACK,
    output oPENDING, oMASK, oREQ_VALID, oREQ_NUM
  );

  modport slave (
    output iMASK_WRITE, iMASK_DATA, iCLEAR_WRITE, iCLEAR_DATA, iREQ_ACK,
    input  oPENDING, oMASK, oREQ_VALID, oREQ_NUM
  );

endinterface

`default_nettype wire

// File: rtl/utim64_irq_prio_enc.sv
// ============================================================================
// Module  : utim64_irq_prio_enc
// Purpose : Combinational lowest-index-wins priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module utim64_irq_prio_enc
  import utim64_irq_ctrl_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int NUM_W  = NUM_W_DEF
) (
  input  wire logic [CH_NUM-1:0] iREQ,
  output logic      [NUM_W-1:0]  oNUM,
  output logic                   oANY
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    oNUM = '0;
    oANY = |iREQ;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (iREQ[i]) begin
        oNUM = NUM_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/utim64_irq_ctrl.sv
// ============================================================================
// Module  : utim64_irq_ctrl
// Purpose : Edge-detect, pending/mask and prioritised request delivery for
//           utim64 IRQs. Optional UTIM64_IRQ_MISS_COUNT_EN adds miss counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module utim64_irq_ctrl
  import utim64_irq_ctrl_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int NUM_W  = NUM_W_DEF
`ifdef UTIM64_IRQ_MISS_COUNT_EN
  ,
  parameter int MISS_W = MISS_W_DEF
`endif
) (
  input  wire logic                     iTIMER_CLOCK,
  input  wire logic                     inRESET,
  input  wire logic [CH_NUM-1:0]        iIRQ,
`ifdef UTIM64_IRQ_MISS_COUNT_EN
  output logic      [CH_NUM*MISS_W-1:0] oMISS_COUNT,
`endif
  utim64_irq_ctrl_if.master             bus
);

  logic [CH_NUM-1:0] r_prev;
  logic [CH_NUM-1:0] r_pending;
  logic [CH_NUM-1:0] r_mask;
  irq_state_t        r_state;
  logic              r_req_valid;
  logic [NUM_W-1:0]  r_req_num;

  logic [CH_NUM-1:0] w_event;
  logic [CH_NUM-1:0] w_sw_clr;
  logic [CH_NUM-1:0] w_ack_clr;
  logic [CH_NUM-1:0] w_clr;
  logic [CH_NUM-1:0] w_cand;
  logic [NUM_W-1:0]  w_win_num;
  logic              w_win_any;
  logic              w_ack;

  assign w_event  = iIRQ & ~r_prev;
  assign w_sw_clr = bus.iCLEAR_WRITE ? bus.iCLEAR_DATA : '0;
  assign w_ack    = (r_state == ST_REQ) && bus.iREQ_ACK;
  assign w_ack_clr = w_ack ? ({{(CH_NUM-1){1'b0}}, 1'b1} << r_req_num) : '0;
  assign w_clr    = w_sw_clr | w_ack_clr;
  assign w_cand   = r_pending & r_mask;

  utim64_irq_prio_enc #(
    .CH_NUM (CH_NUM),
    .NUM_W  (NUM_W)
  ) u_prio_enc (
    .iREQ (w_cand),
    .oNUM (w_win_num),
    .oANY (w_win_any)
  );

  // A fresh edge always beats a same-cycle clear of that bit.
  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_prev    <= iIRQ;
      r_pending <= w_event | (r_pending & ~w_clr);
      if (bus.iMASK_WRITE) begin
        r_mask <= bus.iMASK_DATA;
      end
    end
  end

  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_num   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_req_num   <= w_win_num;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The request is held regardless of mask/clear until acknowledged.
          if (bus.iREQ_ACK) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_req_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oPENDING   = r_pending;
  assign bus.oMASK      = r_mask;
  assign bus.oREQ_VALID = r_req_valid;
  assign bus.oREQ_NUM   = r_req_num;

`ifdef UTIM64_IRQ_MISS_COUNT_EN
  for (genvar k = 0; k < CH_NUM; k++) begin : g_miss
    logic [MISS_W-1:0] r_cnt;
    logic              w_hit;

    assign w_hit = w_event[k] & r_pending[k];

    always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
        r_cnt <= '0;
      end else if (w_sw_clr[k]) begin
        r_cnt <= w_hit ? {{(MISS_W-1){1'b0}}, 1'b1} : '0;
      end else if (w_hit && !w_clr[k] && (r_cnt != {MISS_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign oMISS_COUNT[k*MISS_W +: MISS_W] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_utim64_irq_ctrl.sv
// ============================================================================
// Module  : tb_utim64_irq_ctrl
// Purpose : Scoreboard bench for utim64_irq_ctrl (directed + random stimulus).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_utim64_irq_ctrl;
  import utim64_irq_ctrl_pkg::*;

  localparam int CH = 4;
  localparam int NW = 2;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CH-1:0] irq;

  utim64_irq_ctrl_if #(.CH_NUM(CH), .NUM_W(NW)) bus ();

`ifdef UTIM64_IRQ_MISS_COUNT_EN
  logic [CH*MW-1:0] miss_count;
`endif

  utim64_irq_ctrl #(.CH_NUM(CH), .NUM_W(NW)) dut (
    .iTIMER_CLOCK (clk),
    .inRESET      (rstn),
    .iIRQ         (irq),
`ifdef UTIM64_IRQ_MISS_COUNT_EN
    .oMISS_COUNT  (miss_count),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [NW-1:0] num;
    logic [CH-1:0] pend;
    logic [CH-1:0] mask;
    logic [31:0]   miss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: which channels are pending, enabled, outstanding request.
  logic [CH-1:0] m_prev, m_pend, m_mask;
  bit            m_busy;
  int            m_req;
  int            m_miss[CH];

  function automatic int lowest(input logic [CH-1:0] c);
    for (int i = 0; i < CH; i++) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = '0; m_busy = 0; m_req = 0;
    for (int i = 0; i < CH; i++) m_miss[i] = 0;
  endtask

  task automatic step(input logic [CH-1:0] i_irq, input logic mw, input logic [CH-1:0] md,
                      input logic cw, input logic [CH-1:0] cd, input logic ack);
    logic [CH-1:0] ev, clr, nxt;
    bit   acc;
    exp_t e;
    @(negedge clk);
    irq = i_irq;
    bus.iMASK_WRITE = mw; bus.iMASK_DATA = md;
    bus.iCLEAR_WRITE = cw; bus.iCLEAR_DATA = cd;
    bus.iREQ_ACK = ack;
    ev  = i_irq & ~m_prev;
    clr = cw ? cd : '0;
    acc = m_busy && ack;
    if (acc) clr[m_req] = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (cw && cd[k])                          m_miss[k] = (ev[k] && m_pend[k]) ? 1 : 0;
      else if (ev[k] && m_pend[k] && !clr[k])   m_miss[k] = (m_miss[k] >= 255) ? 255 : m_miss[k] + 1;
    end
    nxt = ev | (m_pend & ~clr);
    if (acc) m_busy = 0;
    else if (!m_busy && lowest(m_pend & m_mask) >= 0) begin
      m_busy = 1;
      m_req  = lowest(m_pend & m_mask);
    end
    m_pend = nxt;
    if (mw) m_mask = md;
    m_prev = i_irq;
    e.valid = m_busy;
    e.num   = NW'(m_req);
    e.pend  = m_pend;
    e.mask  = m_mask;
    for (int k = 0; k < CH; k++) e.miss[k*8 +: 8] = 8'(m_miss[k]);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0, '0, ack);
  endtask

  // Monitor: compares the DUT state after every active edge against the queue.
  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (bus.oREQ_VALID == e.valid) && (!e.valid || bus.oREQ_NUM == e.num) &&
             (bus.oPENDING == e.pend) && (bus.oMASK == e.mask);
`ifdef UTIM64_IRQ_MISS_COUNT_EN
        ok = ok && (miss_count == e.miss);
`endif
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL state t=%0t: got valid=%0b num=%0d pend=%b mask=%b, expected valid=%0b num=%0d pend=%b mask=%b",
                   $time, bus.oREQ_VALID, bus.oREQ_NUM, bus.oPENDING, bus.oMASK,
                   e.valid, e.num, e.pend, e.mask);
`ifdef UTIM64_IRQ_MISS_COUNT_EN
          $display("  miss got=%h expected=%h", miss_count, e.miss);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    irq = '0;
    bus.iMASK_WRITE = 1'b0; bus.iMASK_DATA = '0;
    bus.iCLEAR_WRITE = 1'b0; bus.iCLEAR_DATA = '0;
    bus.iREQ_ACK = 1'b0;
    model_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.oREQ_VALID, bus.oREQ_NUM, bus.oPENDING, bus.oMASK} != '0) begin
      errors++;
      $display("FAIL reset: got valid=%0b num=%0d pend=%b mask=%b, expected all 0",
               bus.oREQ_VALID, bus.oREQ_NUM, bus.oPENDING, bus.oMASK);
    end
    rstn = 1'b1;

    // Single pulse on channel 2, then ack.
    step('0, 1'b1, 4'hF, 1'b0, '0, 1'b0);
    step(4'b0100, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    step('0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(2, 1'b0);

    // Two simultaneous events: channel 1 first, then 3.
    step(4'b1010, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4, 1'b0);
    step('0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(3, 1'b0);
    step('0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(2, 1'b0);

    // Masked channel latches pending without a request until unmasked.
    step('0, 1'b1, 4'h0, 1'b0, '0, 1'b1);
    step(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4, 1'b0);
    step('0, 1'b1, 4'h1, 1'b0, '0, 1'b0);
    idle(3, 1'b0);
    step('0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(2, 1'b0);

    // Level held high for 20 cycles yields one event.
    step('0, 1'b1, 4'hF, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b0, '0, 1'b0, '0, (i == 6));
    idle(3, 1'b0);

    // Event and software clear on the same bit: event wins.
    step('0, 1'b1, 4'h0, 1'b0, '0, 1'b0);
    step(4'b0010, 1'b0, '0, 1'b1, 4'b0010, 1'b0);
    idle(2, 1'b0);
    step('0, 1'b0, '0, 1'b1, 4'hF, 1'b0);
    idle(1, 1'b0);

`ifdef UTIM64_IRQ_MISS_COUNT_EN
    // Saturating miss counter on channel 0, then clear.
    for (int i = 0; i < 300; i++) begin
      step(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0);
      step('0, 1'b0, '0, 1'b0, '0, 1'b0);
    end
    step('0, 1'b0, '0, 1'b1, 4'b0001, 1'b0);
    idle(2, 1'b0);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(CH'($urandom_range(0, 15) & $urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0), CH'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), CH'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0));
    end
    idle(3, 1'b1);

    // Asynchronous reset while a request is outstanding.
    step('0, 1'b1, 4'hF, 1'b0, '0, 1'b0);
    step(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.oREQ_VALID !== 1'b0 || bus.oPENDING !== '0 || bus.oMASK !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%0b pend=%b mask=%b, expected 0/0000/0000",
               bus.oREQ_VALID, bus.oPENDING, bus.oMASK);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(4'b0100, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(3, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/utim64_irq_ctrl.md
Name: utim64_irq_ctrl

Overview:
- Interrupt delivery stage directly downstream of the user timer; consumes its per-comparator IRQ outputs (oIRQ_IRQ[3:0]) in the timer clock domain.
- Detects rising edges, latches per-channel pending bits, applies a mask, and presents one prioritised request at a time to the core interrupt controller over a valid/ack handshake.
- Also holds software-visible pending/mask state for the DPS register interface.

Parameters:
- CH_NUM, 4, number of IRQ channels; must equal 2**NUM_W.
- NUM_W, 2, width of the channel-number field.
- MISS_W, 8, width of each per-channel missed-interrupt counter (optional feature only).

Ports:
- iTIMER_CLOCK  in  1  clock; the timer domain, same clock as utim64 comparators.
- inRESET  in  1  reset; asynchronous, active-low.
- iIRQ  in  CH_NUM  raw IRQ lines from utim64 oIRQ_IRQ; level or pulse.
- iMASK_WRITE  in  1  one-cycle strobe; load the mask register.
- iMASK_DATA  in  CH_NUM  new mask; 1 = channel enabled.
- iCLEAR_WRITE  in  1  one-cycle strobe; write-1-to-clear pending bits.
- iCLEAR_DATA  in  CH_NUM  pending bits to clear.
- oPENDING  out  CH_NUM  pending register, unmasked view.
- oMASK  out  CH_NUM  current mask.
- oREQ_VALID  out  1  request to the interrupt controller.
- oREQ_NUM  out  NUM_W  channel being requested.
- iREQ_ACK  in  1  interrupt controller accepts the request.

Behaviour:
- Reset: all outputs 0; pending = 0; mask = 0; previous-IRQ register = 0; FSM in IDLE.
- Edge detect:
  - Register iIRQ once per cycle (prev).
  - An event on channel k is iIRQ[k] & ~prev[k].
  - An input held high produces exactly one event.
- Pending update, one cycle after the event:
  - pending[k] <= event[k] | (pending[k] & ~clr[k]).
  - clr = (iCLEAR_WRITE ? iCLEAR_DATA : 0) | ack_clear.
  - If an event and a clear hit the same bit in the same cycle, the event wins and the bit stays 1.
- Mask:
  - iMASK_WRITE loads the mask next cycle.
  - Masked channels still latch pending; they are never requested.
- Candidate set: pending & mask. Priority is fixed: lowest channel index wins.
- FSM:
  - IDLE: if the candidate set is non-zero, capture the winner into oREQ_NUM, set oREQ_VALID = 1, go to REQ.
  - REQ:
    - oREQ_VALID and oREQ_NUM are held stable until iREQ_ACK is sampled high.
    - On ack: ack_clear = one-hot(oREQ_NUM) in that same cycle; oREQ_VALID drops next cycle; go to IDLE.
    - The request is never withdrawn: mask or clear writes during REQ do not lower oREQ_VALID or change oREQ_NUM. An ack on an already-cleared channel is harmless.
  - IDLE after ACK takes one cycle before the next request can be raised. Minimum spacing between requests is 2 cycles.
- Latency: iIRQ rises at cycle n -> pending at n+1 -> oREQ_VALID at n+2 (channel unmasked, FSM idle).
- iREQ_ACK while in IDLE is ignored.
- Reset asserted mid-request: oREQ_VALID drops immediately (asynchronous) and all pending state is lost.

Optional Feature:
- Macro: UTIM64_IRQ_MISS_COUNT_EN.
- When defined:
  - Adds per-channel saturating MISS_W-bit counters, exposed as output oMISS_COUNT (CH_NUM*MISS_W bits, channel 0 in the LSBs).
  - A counter increments when an event arrives while pending[k] is already 1 and not being cleared in that cycle. It saturates at all-ones.
  - iCLEAR_WRITE with bit k set also zeroes counter k. If increment and clear coincide, the result is 1.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: CH_NUM/NUM_W defaults and the FSM state encodings (IDLE = 1'b0, REQ = 1'b1).
- One natural sub-module: utim64_irq_prio_enc, a combinational lowest-index priority encoder (CH_NUM in -> NUM_W out plus any-valid flag).

Test Plan:
- Reset, then mask = 4'hF, pulse iIRQ[2] for 1 cycle at n -> oREQ_VALID = 1, oREQ_NUM = 2 at n+2; ack -> pending = 0 and oREQ_VALID = 0 next cycle.
- iIRQ = 4'b1010 in the same cycle -> requests channel 1 then channel 3, each held until acked; oPENDING goes 1010 -> 1000 -> 0000.
- Mask = 4'h0, pulse iIRQ[0] -> oPENDING = 4'b0001, no request; write mask = 4'h1 -> oREQ_VALID two cycles later.
- Hold iIRQ[3] high for 20 cycles -> exactly one event and one request.
- Event on channel 1 in the same cycle as an iCLEAR_WRITE of 4'b0010 -> pending[1] remains 1.
- UTIM64_IRQ_MISS_COUNT_EN: 300 pulses on channel 0 with no ack and MISS_W = 8 -> counter reads 255; clear 4'b0001 -> counter 0, pending 0.
